vid_palette_loader: RTL and testbench
=====================================

Name: vid_palette_loader

Overview:
- Upstream feeder for the video palette RAM.
- Accepts a byte stream of R,G,B triplets over a valid/ready handshake and packs each triplet into one 24-bit entry.
- Writes each entry through the palette write port (8-bit address, 24-bit data, enable).
- Can hold off accepting bytes outside vertical blanking, so palette changes (e.g. damage/pickup flashes) do not tear mid-frame.

Parameters:
- WAIT_VBLANK, 1, 1 = input bytes are accepted only while vblank is high; 0 = accepted at any time.

Ports:
- clk  in  1  video clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load. Ignored while busy.
- start_idx  in  8  first palette index, sampled on start.
- count  in  9  number of entries, 0..256, sampled on start.
- abort  in  1  cancels the current load.
- vblank  in  1  vertical blanking level from video timing.
- in_data  in  8  colour byte; order is R, G, B.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts in_data this cycle.
- pal_w_addr  out  8  palette write address.
- pal_w_data  out  24  palette write data, {R,G,B}.
- pal_w_ena  out  1  palette write strobe.
- busy  out  1  a load is in progress.
- done  out  1  one-cycle pulse when a load completes.

Behaviour:
- Reset values: in_ready=0, pal_w_ena=0, pal_w_addr=0, pal_w_data=0, busy=0, done=0. Internally: state=IDLE, byte phase=0, entry counter=0.
- States: IDLE, LOAD, FLUSH.
- IDLE:
  - start with count!=0: latch idx=start_idx and remaining=count; byte phase=0; go to LOAD; busy=1 from the next cycle.
  - start with count==0: stay in IDLE; done=1 on the next cycle; no writes.
- LOAD:
  - in_ready = (WAIT_VBLANK==0) | vblank. Combinational from state and vblank only; does not depend on in_valid.
  - A byte is accepted on a clock edge where in_valid & in_ready.
  - Phase 0 stores R in data[23:16], phase 1 stores G in data[15:8], phase 2 stores B in data[7:0]. Phase advances 0→1→2→0 on accepted bytes only.
  - Accepting the B byte at edge N: in cycle N+1, pal_w_ena=1, pal_w_addr=idx, pal_w_data={R,G,B}. The strobe is exactly one cycle wide.
  - Also at edge N: idx increments mod 256 (255 wraps to 0) and remaining decrements. If remaining becomes 0, go to FLUSH.
  - Back-to-back triplets sustain one entry per 3 accepted bytes, with no bubbles inserted by the loader.
- FLUSH:
  - Lasts one cycle; the final pal_w_ena is high during it; in_ready=0.
  - Next cycle: done=1, busy=0, state=IDLE.
- vblank falling mid-triplet (WAIT_VBLANK=1): in_ready drops. Partial R/G bytes and the phase are retained, and acceptance resumes at the next vblank.
- abort (any state, highest priority over start and byte acceptance):
  - Next state IDLE; partial triplet discarded; phase=0.
  - No done pulse; busy=0 next cycle.
  - A pal_w_ena already scheduled for the cycle after abort (B accepted on the same edge as abort is not accepted; abort wins) does not occur.
- start while busy is ignored; no re-latch.
- pal_w_addr and pal_w_data hold their last values while pal_w_ena=0.
- No reads of palette memory; the read side is owned by the pixel pipeline. The palette write port accepts one write per cycle, so no backpressure from it exists.
- Asserting rst_n low mid-load immediately forces all reset values; no write is emitted.

Test Plan:
- WAIT_VBLANK=0, start_idx=0x10, count=2, bytes 11,22,33,44,55,66 with in_valid always high → pal_w_ena pulses 3 cycles apart: addr 0x10 data 0x112233, then addr 0x11 data 0x445566; done 1 cycle after the second write; busy low afterwards.
- start_idx=0xFF, count=2 → writes to 0xFF then 0x00 (wrap). count=256 from idx 0 with a random in_valid pattern → 256 writes, every address written exactly once, data matches the stream.
- WAIT_VBLANK=1, vblank low at start → in_ready=0 and no acceptance. Raise vblank → R,G accepted; drop vblank → stall with no write. Raise again → B accepted; write 0x{R}{G}{B} at the correct address.
- count=0 start → done pulse next cycle, zero pal_w_ena, busy never high. start pulse while busy → ignored; the original load completes unchanged.
- abort after R,G of the second entry, and separately on the same edge as a B byte → no further pal_w_ena, no done, busy=0 next cycle. A new start then loads correctly from phase 0.
- rst_n asserted asynchronously mid-triplet (between edges) → outputs at reset values immediately. After release, a fresh load behaves as in scenario 1.

Source files
------------

// File: rtl/vid_palette_loader.sv
// Palette RAM feeder: packs R,G,B bytes from a valid/ready stream into 24-bit
// entries and writes them to consecutive palette indices, optionally only in vblank.
module vid_palette_loader #(
  parameter bit WAIT_VBLANK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  start_idx,
  input  logic [8:0]  count,
  input  logic        abort,
  input  logic        vblank,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  pal_w_addr,
  output logic [23:0] pal_w_data,
  output logic        pal_w_ena,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0] state;
  logic [1:0] phase;
  logic [7:0] idx;
  logic [8:0] remaining;
  logic [7:0] r_byte;
  logic [7:0] g_byte;
  logic       accept;

  assign in_ready = (state == ST_LOAD) && (!WAIT_VBLANK || vblank);
  // abort outranks a byte presented on the same edge
  assign accept   = in_valid && in_ready && !abort;
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      phase      <= 2'd0;
      idx        <= 8'd0;
      remaining  <= 9'd0;
      r_byte     <= 8'd0;
      g_byte     <= 8'd0;
      pal_w_addr <= 8'd0;
      pal_w_data <= 24'd0;
      pal_w_ena  <= 1'b0;
      done       <= 1'b0;
    end else begin
      pal_w_ena <= 1'b0;
      done      <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
        phase <= 2'd0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              if (count == 9'd0) begin
                done <= 1'b1;
              end else begin
                idx       <= start_idx;
                remaining <= count;
                phase     <= 2'd0;
                state     <= ST_LOAD;
              end
            end
          end
          ST_LOAD: begin
            if (accept) begin
              case (phase)
                2'd0: begin
                  r_byte <= in_data;
                  phase  <= 2'd1;
                end
                2'd1: begin
                  g_byte <= in_data;
                  phase  <= 2'd2;
                end
                2'd2: begin
                  pal_w_ena  <= 1'b1;
                  pal_w_addr <= idx;
                  pal_w_data <= {r_byte, g_byte, in_data};
                  idx        <= idx + 8'd1;
                  remaining  <= remaining - 9'd1;
                  phase      <= 2'd0;
                  if (remaining == 9'd1) state <= ST_FLUSH;
                end
                default: phase <= 2'd0;
              endcase
            end
          end
          ST_FLUSH: begin
            // the last write strobe is visible during this cycle
            state <= ST_IDLE;
            done  <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vid_palette_loader.sv
// Randomized bench for vid_palette_loader: one instance without and one with vblank gating,
// checked cycle by cycle against a byte/entry-level model of the load sequence.
module tb_vid_palette_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, start1, abort0, abort1;
  logic [7:0]  start_idx;
  logic [8:0]  count;
  logic        vblank;
  logic [7:0]  in_data;
  logic        in_valid;

  logic        rdy0, ena0, busy0, done0, rdy1, ena1, busy1, done1;
  logic [7:0]  addr0, addr1;
  logic [23:0] data0, data1;

  always #5 clk = ~clk;

  vid_palette_loader #(.WAIT_VBLANK(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .start_idx(start_idx), .count(count),
    .abort(abort0), .vblank(vblank), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy0), .pal_w_addr(addr0), .pal_w_data(data0), .pal_w_ena(ena0),
    .busy(busy0), .done(done0));

  vid_palette_loader #(.WAIT_VBLANK(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .start_idx(start_idx), .count(count),
    .abort(abort1), .vblank(vblank), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy1), .pal_w_addr(addr1), .pal_w_data(data1), .pal_w_ena(ena1),
    .busy(busy1), .done(done1));

  logic sel;
  int   n_chk = 0;
  int   n_pass = 0;

  // reference model: bytes still owed by the stream, bytes of the open triplet,
  // and the expected outputs after the next edge
  int          m_left;
  logic        m_tail;
  logic [7:0]  m_idx;
  logic [7:0]  bq[$];
  logic [7:0]  fixed_q[$];
  logic        e_busy, e_done, e_wv;
  logic [7:0]  e_wa;
  logic [23:0] e_wd;
  int          written[256];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic model_clear();
    m_left = 0; m_tail = 1'b0; bq.delete();
    e_busy = 1'b0; e_done = 1'b0; e_wv = 1'b0;
  endtask

  task automatic cyc(input logic v, input logic vb, input logic ab,
                     input logic st, input logic [7:0] si, input logic [8:0] sc);
    logic        exp_rdy, n_busy, n_done, n_wv;
    logic [7:0]  cur;
    @(negedge clk);
    chk("busy", sel ? busy1 : busy0, e_busy);
    chk("done", sel ? done1 : done0, e_done);
    chk("w_ena", sel ? ena1 : ena0, e_wv);
    if (e_wv) begin
      chk("w_addr", sel ? addr1 : addr0, e_wa);
      chk("w_data", sel ? data1 : data0, e_wd);
      written[e_wa]++;
    end
    chk("idle_inst", sel ? {ena0, busy0, done0} : {ena1, busy1, done1}, 0);
    cur = (fixed_q.size() > 0) ? fixed_q[0] : 8'($urandom);
    in_valid = v; vblank = vb; in_data = cur;
    abort0 = ab && !sel; abort1 = ab && sel;
    start0 = st && !sel; start1 = st && sel;
    start_idx = si; count = sc;
    #1;
    exp_rdy = (m_left > 0) && (!sel || vb);
    chk("in_ready", sel ? rdy1 : rdy0, exp_rdy);
    n_busy = e_busy; n_done = 1'b0; n_wv = 1'b0;
    if (ab) begin
      m_left = 0; m_tail = 1'b0; bq.delete(); n_busy = 1'b0;
    end else if (m_tail) begin
      m_tail = 1'b0; n_busy = 1'b0; n_done = 1'b1;
    end else if (st && !e_busy) begin
      if (sc == 0) n_done = 1'b1;
      else begin
        m_idx = si; m_left = 3 * int'(sc); n_busy = 1'b1;
      end
    end else if (v && exp_rdy) begin
      bq.push_back(cur);
      if (fixed_q.size() > 0) void'(fixed_q.pop_front());
      m_left--;
      if (bq.size() == 3) begin
        n_wv = 1'b1; e_wa = m_idx; e_wd = {bq[0], bq[1], bq[2]};
        bq.delete(); m_idx = m_idx + 8'd1;
        if (m_left == 0) m_tail = 1'b1;
      end
    end
    e_busy = n_busy; e_done = n_done; e_wv = n_wv;
  endtask

  task automatic run_idle(input int pct, input int vbm);
    int n = 0;
    while ((m_left != 0 || m_tail) && n < 5000) begin
      cyc($urandom_range(0, 99) < pct, (vbm == 2) ? 1'($urandom_range(0, 1)) : 1'(vbm),
          1'b0, 1'b0, 8'd0, 9'd0);
      n++;
    end
    if (n >= 5000) chk("timeout", 1, 0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 9'd0);
  endtask

  task automatic load(input logic [7:0] si, input logic [8:0] sc, input int pct, input int vbm);
    cyc(1'b0, vbm == 1, 1'b0, 1'b1, si, sc);
    run_idle(pct, vbm);
  endtask

  task automatic check_reset_outputs();
    chk("rst_rdy", sel ? rdy1 : rdy0, 0);
    chk("rst_ena", sel ? ena1 : ena0, 0);
    chk("rst_addr", sel ? addr1 : addr0, 0);
    chk("rst_data", sel ? data1 : data0, 0);
    chk("rst_busy", sel ? busy1 : busy0, 0);
    chk("rst_done", sel ? done1 : done0, 0);
  endtask

  initial begin
    int bad;
    rst_n = 1'b0; start0 = 0; start1 = 0; abort0 = 0; abort1 = 0;
    start_idx = 0; count = 0; vblank = 0; in_data = 0; in_valid = 0; sel = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    check_reset_outputs();
    sel = 1'b1; check_reset_outputs(); sel = 1'b0;
    rst_n = 1'b1;

    // basic two-entry load with a fixed byte stream
    fixed_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    load(8'h10, 9'd2, 100, 0);

    // index wrap and full-palette load with random valid
    load(8'hFF, 9'd2, 70, 0);
    foreach (written[i]) written[i] = 0;
    load(8'h00, 9'd256, 60, 0);
    bad = 0;
    foreach (written[i]) if (written[i] != 1) bad++;
    chk("full_cover", bad, 0);

    // count==0 start: done only
    load(8'h05, 9'd0, 100, 0);

    // start while busy is ignored
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h20, 9'd2);
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 9'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h80, 9'd5);
    run_idle(100, 0);

    // abort after R,G of the second entry
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h30, 9'd3);
    repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 9'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 9'd0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 9'd0);
    // abort on the same edge as the B byte
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h40, 9'd2);
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 9'd0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 9'd0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 9'd0);
    load(8'h50, 9'd2, 100, 0);

    // vblank gating: stall before vblank, and again between G and B
    sel = 1'b1;
    fixed_q = '{8'hAB, 8'hCD, 8'hEF};
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h40, 9'd1);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 9'd0);
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 9'd0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 9'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 9'd0);
    run_idle(100, 1);
    load(8'($urandom), 9'($urandom_range(1, 20)), 70, 2);
    sel = 1'b0;

    // asynchronous reset between edges, mid-triplet
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h60, 9'd3);
    repeat (4) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 9'd0);
    #2 rst_n = 1'b0; in_valid = 1'b0;
    #1 check_reset_outputs();
    model_clear();
    @(negedge clk); rst_n = 1'b1;
    fixed_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    load(8'h10, 9'd2, 100, 0);
    load(8'($urandom), 9'($urandom_range(1, 30)), 50, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
